// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 32-bit ALU: decodes one instruction at a time
// (IDLE -> EXEC -> WB), owns the 8-entry register file, condition flags and the PC.
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_imm_val,
  output logic              alu_imm,
  output logic [3:0]        alu_func,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [7:0]        alu_status,
  output logic [PC_W-1:0]   pc,
  output logic [7:0]        flags,
  output logic              retire,
  output logic              err,
  output logic              halted,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2**REG_AW;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t              state_reg, state_next;
  logic [29:0]         instr_reg;
  logic [DATA_W-1:0]   result_reg;
  logic [PC_W-1:0]     pc_reg;
  logic [7:0]          flags_reg;
  logic                retire_reg, err_reg, halted_reg;
  logic [DATA_W-1:0]   rf [NREG];

  logic [3:0]          op;
  logic                imm_sel;
  logic [REG_AW-1:0]   rd, ra, rb;
  logic [15:0]         imm16;
  logic                accept;
  logic                wb_we;
  logic [PC_W-1:0]     pc_inc;
  logic                unused_bits;

  // Reserved instruction bits [17:16] are not stored.
  assign unused_bits = ^instr[17:16];

  assign op      = instr_reg[29:26];
  assign imm_sel = instr_reg[25];
  assign rd      = instr_reg[24:22];
  assign ra      = instr_reg[21:19];
  assign rb      = instr_reg[18:16];
  assign imm16   = instr_reg[15:0];

  assign accept  = (state_reg == IDLE) && instr_valid && !halted_reg;
  assign wb_we   = (state_reg == WB) && (op < 4'd12);
  assign pc_inc  = pc_reg + 1'b1;

  assign pc       = pc_reg;
  assign flags    = flags_reg;
  assign retire   = retire_reg;
  assign err      = err_reg;
  assign halted   = halted_reg;
  assign dbg_data = rf[dbg_addr];

  // Register 0 is hard-wired to zero; other entries write only in WB.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
    if (gi == 0) begin : g_zero
      assign rf[gi] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] q_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (wb_we && (rd == REG_AW'(gi))) begin
          q_reg <= result_reg;
        end
      end
      assign rf[gi] = q_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_imm_val = '0;
    alu_imm     = 1'b0;
    alu_func    = 4'd0;
    case (state_reg)
      IDLE: begin
        instr_ready = !halted_reg;
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        alu_a       = rf[ra];
        alu_b       = rf[rb];
        alu_imm     = imm_sel;
        alu_imm_val = {{(DATA_W-16){1'b0}}, imm16};
        if (op < 4'd12)       alu_func = op;
        else if (op == 4'd12) alu_func = 4'd2;
        state_next = WB;
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      instr_reg  <= '0;
      result_reg <= '0;
      pc_reg     <= '0;
      flags_reg  <= '0;
      retire_reg <= 1'b0;
      err_reg    <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      retire_reg <= 1'b0;
      err_reg    <= 1'b0;
      if (accept) instr_reg <= {instr[31:18], instr[15:0]};
      if (state_reg == EXEC) result_reg <= alu_out;
      if (state_reg == WB) begin
        retire_reg <= 1'b1;
        case (op)
          4'd13: begin
            // Conditions 6 and 7 do not exist; they flag an error and fall through.
            if (rd < 3'd6) begin
              pc_reg <= flags_reg[rd] ? PC_W'(imm16) : pc_inc;
            end else begin
              err_reg <= 1'b1;
              pc_reg  <= pc_inc;
            end
          end
          4'd14: halted_reg <= 1'b1;
          4'd15: begin
            err_reg <= 1'b1;
            pc_reg  <= pc_inc;
          end
          default: begin
            flags_reg <= alu_status;
            pc_reg    <= pc_inc;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/writeback controller on the consumer side of the 32-bit ALU.
- Accepts instruction words over a valid/ready handshake and decodes them into ALU operand/function drive.
- Captures the ALU result and the clock-latched status byte, writes results to an internal 8x32 register file, keeps condition flags and maintains the program counter (PC) for conditional branches.
- One instruction in flight; 3 cycles per instruction.

Parameters:
- DATA_W, 32, datapath and register width
- PC_W, 16, program counter width
- REG_AW, 3, register address width (2**REG_AW registers)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction word valid
- instr_ready  out  1  controller can accept an instruction
- instr  in  32  instruction word
- alu_a  out  DATA_W  operand A (register ra)
- alu_b  out  DATA_W  operand B (register rb)
- alu_imm_val  out  DATA_W  zero-extended imm16
- alu_imm  out  1  select immediate instead of alu_a
- alu_func  out  4  ALU function code
- alu_out  in  DATA_W  ALU combinational result
- alu_status  in  8  ALU status byte, latched by the ALU on clk
- pc  out  PC_W  program counter
- flags  out  8  last captured ALU status
- retire  out  1  one-cycle pulse per completed instruction
- err  out  1  one-cycle pulse on illegal instruction or condition
- halted  out  1  sticky halt indicator
- dbg_addr  in  REG_AW  debug register-read address
- dbg_data  out  DATA_W  combinational read of register dbg_addr

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Instruction format:
  - [31:28] op
  - [27] imm
  - [26:24] rd (cond index for BR)
  - [23:21] ra
  - [20:18] rb
  - [17:16] ignored
  - [15:0] imm16
- Op codes:
  - op 0-11: ALU operation; alu_func = op; writes rd.
  - op 12: CMP; alu_func = 2 (SUB); no writeback.
  - op 13: BR; no ALU use.
  - op 14: HALT.
  - op 15: illegal.
- Reset:
  - State returns to IDLE; all registers, pc, flags and the register file clear to 0.
  - halted, err and retire clear to 0. alu_func = 0 (NOP); alu_imm = 0.
  - Asserting reset mid-instruction discards the instruction; no writeback occurs.
- Register 0 always reads 0; writes to it are dropped.
- FSM IDLE -> EXEC -> WB -> IDLE:
  - IDLE:
    - instr_ready = ~halted.
    - ALU inputs driven to NOP with operands 0.
    - Handshake (instr_valid & instr_ready) at edge E0 latches instr and moves to EXEC.
  - EXEC (one cycle):
    - alu_a/alu_b = reg[ra]/reg[rb]; alu_imm = instr[27]; alu_imm_val = {0, imm16}; alu_func per op.
    - All ALU drive is held stable for the whole cycle.
    - Edge E1 captures alu_out into a result register. The ALU latches its status at the same edge.
  - WB (one cycle): ALU drive returns to NOP. Edge E2 performs the following, then returns to IDLE:
    - op 0-11: reg[rd] <= result; flags <= alu_status; pc <= pc+1.
    - CMP: flags <= alu_status; pc <= pc+1.
    - BR with cond = rd in 0..5: if flags[cond] = 1 then pc <= imm16[PC_W-1:0], else pc <= pc+1.
    - BR with cond 6..7: err pulse; pc <= pc+1.
    - HALT: halted <= 1; pc unchanged.
    - op 15: err pulse; pc <= pc+1; no writeback; flags unchanged.
    - retire pulses during the cycle after E2 for every op, including illegal ones.
- Throughput and latency:
  - instr_ready is low in EXEC and WB, so the next accept occurs at the earliest at E3.
  - An instruction reading rd written by the previous instruction sees the new value (the write completes before EXEC).
- Widths and arithmetic:
  - pc wraps modulo 2**PC_W.
  - The result is truncated to DATA_W.
  - Operations that ignore rb still drive alu_b = reg[rb].
- HALT: instr_ready stays 0 until reset; instr_valid is ignored.
- instr is sampled only at the handshake edge. Changes to instr while not ready are ignored.

Test Plan:
- ADDI: op1, imm=1, rd=1, ra=0, rb=0, imm16=5, then op1, imm=1, rd=2, rb=1, imm16=7 -> reg1=5, reg2=12, pc=2, two retire pulses each 3 cycles apart, flags=0x06.
- CMP r1,r2 (5 vs 12) -> flags=0x32 (NEQU, LTHAN, LEQUAL); reg file unchanged; pc +1.
- BR cond=4, imm16=0x0040 after the CMP -> pc=0x0040. BR cond=0 -> pc=0x0041. BR cond=7 -> err pulse, pc=0x0042.
- Write r0 (op1 imm, rd=0, imm16=9) -> dbg_data at addr 0 = 0. op15 -> err pulse, flags unchanged.
- HALT -> halted=1, instr_ready=0 for 20 cycles with instr_valid=1; pc frozen.
- rst_n low during EXEC of ADDI rd=3 -> reg3=0, pc=0, state IDLE, instr_ready=1 on the first cycle after rst_n is released.
